// File: rtl/data_memory_ctrl.sv
// Single-port data memory with a valid/ready request channel, registered read
// response with backpressure, optional clear sweep after reset and range checks.
module data_memory_ctrl #(
  parameter int                DATA_W        = 18,
  parameter int                ADDR_W        = 10,
  parameter int                DEPTH         = 1024,
  parameter bit                INIT_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VALUE    = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              wr_err,
  output logic              init_done
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_L  = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  state_t            state;
  logic [ADDR_W:0]   init_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              addr_ok;
  logic              accept;
  logic              acc_wr;
  logic              acc_rd;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_din;

  // Compare against DEPTH with one extra bit so DEPTH == 2**ADDR_W never errors.
  assign addr_ok   = {1'b0, req_addr} < DEPTH_L;
  assign req_ready = (state == ST_IDLE) && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign acc_wr    = accept && req_write;
  assign acc_rd    = accept && !req_write;

  // The sweep and accepted writes share the single write port.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    mem_we  = 1'b0;
    mem_idx = req_addr[IDX_W-1:0];
    mem_din = req_wdata;
    if (state == ST_INIT) begin
      mem_we  = 1'b1;
      mem_idx = init_ptr[IDX_W-1:0];
      mem_din = INIT_VALUE;
    end else if (acc_wr && addr_ok) begin
      mem_we = 1'b1;
    end
  end

  // NOTE: the array has no reset so it can map onto a RAM macro; the sweep clears it instead.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state     <= INIT_ON_RESET ? ST_INIT : ST_IDLE;
      init_ptr  <= '0;
      init_done <= !INIT_ON_RESET;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          init_ptr <= init_ptr + ONE_L;
          if (init_ptr == LAST_L) begin
            state     <= ST_IDLE;
            init_done <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (acc_rd) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= addr_ok ? mem[req_addr[IDX_W-1:0]] : '0;
            rsp_err   <= !addr_ok;
          end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
          end
          if (acc_wr && !addr_ok) wr_err <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
